display_rect_compositor: RTL and testbench

Parametrised rectangle compositor for the Pong display path. It holds NUM_OBJ rectangular objects (paddles, ball, net segments) in double-buffered registers and tests every incoming pixel against all of them in a 2-stage pipeline. For each pixel it outputs a priority-resolved colour and object id, and for each frame it reports a per-object overlap (collision) mask. It sits between the VGA timing generator and the colour DAC, and is written by the game-logic block.

---
 rtl/display_pkg.sv | 36 +++
 rtl/display_rect_hit.sv | 34 +++
 rtl/display_rect_compositor.sv | 170 +++++++++++++++++
 tb/tb_display_rect_compositor.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared defaults, colour names and width helpers for the display path.
package display_pkg;

  localparam int DEFAULT_COORD_W = 10;
  localparam int DEFAULT_SIZE_W  = 8;
  localparam int DEFAULT_COLOR_W = 3;

  // 3-bit RGB colour names (bit 2 = red, bit 1 = green, bit 0 = blue).
  localparam int COLOR_BLACK   = 0;
  localparam int COLOR_BLUE    = 1;
  localparam int COLOR_GREEN   = 2;
  localparam int COLOR_CYAN    = 3;
  localparam int COLOR_RED     = 4;
  localparam int COLOR_MAGENTA = 5;
  localparam int COLOR_YELLOW  = 6;
  localparam int COLOR_WHITE   = 7;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Object index width; never narrower than one bit.
  function automatic int idx_width(input int num_obj);
    return (clog2(num_obj) < 1) ? 1 : clog2(num_obj);
  endfunction

endpackage

// File: rtl/display_rect_hit.sv
// Combinational bounds test of one pixel against one rectangle.
module display_rect_hit
  import display_pkg::*;
#(
  parameter int COORD_W = DEFAULT_COORD_W,
  parameter int SIZE_W  = DEFAULT_SIZE_W
) (
  input  logic [COORD_W-1:0] obj_x,
  input  logic [COORD_W-1:0] obj_y,
  input  logic [SIZE_W-1:0]  obj_w,
  input  logic [SIZE_W-1:0]  obj_h,
  input  logic               obj_vis,
  input  logic [COORD_W-1:0] xpix,
  input  logic [COORD_W-1:0] ypix,
  output logic               hit
);

  localparam int SUM_W = COORD_W + 1;

  // One extra bit keeps the far edge from wrapping for objects that run
  // off the right or bottom of the coordinate space.
  logic [SUM_W-1:0] x_end;
  logic [SUM_W-1:0] y_end;

  assign x_end = {1'b0, obj_x} + SUM_W'(obj_w);
  assign y_end = {1'b0, obj_y} + SUM_W'(obj_h);

  // A zero width or height makes the half-open interval empty, so no
  // separate size check is needed.
  assign hit = obj_vis
             && (xpix >= obj_x) && ({1'b0, xpix} < x_end)
             && (ypix >= obj_y) && ({1'b0, ypix} < y_end);

endmodule

// File: rtl/display_rect_compositor.sv
// Double-buffered rectangle compositor: per-pixel priority colour/id in a
// 2-stage pipeline plus a per-frame object overlap mask.
module display_rect_compositor
  import display_pkg::*;
#(
  parameter int               NUM_OBJ  = 4,
  parameter int               COORD_W  = DEFAULT_COORD_W,
  parameter int               SIZE_W   = DEFAULT_SIZE_W,
  parameter int               COLOR_W  = DEFAULT_COLOR_W,
  parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(COLOR_BLACK),
  localparam int              IDX_W    = idx_width(NUM_OBJ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [SIZE_W-1:0]  wr_w,
  input  logic [SIZE_W-1:0]  wr_h,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               wr_vis,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] xpix,
  input  logic [COORD_W-1:0] ypix,
  output logic               out_valid,
  output logic               out_hit,
  output logic [IDX_W-1:0]   out_id,
  output logic [COLOR_W-1:0] out_color,
  output logic [NUM_OBJ-1:0] collide
);

  typedef struct packed {
    logic               vis;
    logic [COLOR_W-1:0] color;
    logic [SIZE_W-1:0]  h;
    logic [SIZE_W-1:0]  w;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } obj_t;

  obj_t shadow_q [NUM_OBJ];
  obj_t shadow_d [NUM_OBJ];
  obj_t active_q [NUM_OBJ];

  logic wr_ok;
  assign wr_ok = wr_en && (int'(wr_idx) < NUM_OBJ);

  // Shadow set after this cycle's write; also the commit source so a write
  // coinciding with frame_start goes straight through to the active set.
  always_comb begin
    // NOTE: default the whole array first so every path assigns it and no
    // latch is inferred.
    shadow_d = shadow_q;
    if (wr_ok) begin
      shadow_d[wr_idx] = '{vis: wr_vis, color: wr_color, h: wr_h, w: wr_w,
                           y: wr_y, x: wr_x};
    end
  end

  // Shadow and active object registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: these object registers are a handful of flops rather than a
      // RAM, so they are cleared to give a defined, empty scene.
      for (int i = 0; i < NUM_OBJ; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      shadow_q <= shadow_d;
      if (frame_start) begin
        active_q <= shadow_d;
      end
    end
  end

  logic [NUM_OBJ-1:0] hit_vec;

  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_hit
    display_rect_hit #(
      .COORD_W (COORD_W),
      .SIZE_W  (SIZE_W)
    ) u_hit (
      .obj_x   (active_q[i].x),
      .obj_y   (active_q[i].y),
      .obj_w   (active_q[i].w),
      .obj_h   (active_q[i].h),
      .obj_vis (active_q[i].vis),
      .xpix    (xpix),
      .ypix    (ypix),
      .hit     (hit_vec[i])
    );
  end

  logic               s1_valid;
  logic [NUM_OBJ-1:0] s1_hit;
  logic [COLOR_W-1:0] s1_color [NUM_OBJ];

  // Stage 1: capture the hit vector (masked by pix_valid) together with the
  // colours it was tested against, so a commit cannot skew them apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        s1_color[i] <= '0;
      end
    end else begin
      s1_valid <= pix_valid;
      s1_hit   <= pix_valid ? hit_vec : '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        s1_color[i] <= active_q[i].color;
      end
    end
  end

  logic               win_hit;
  logic [IDX_W-1:0]   win_id;
  logic [COLOR_W-1:0] win_color;

  // Priority encode: scanning downwards lets the lowest set index win.
  always_comb begin
    win_hit   = 1'b0;
    win_id    = '0;
    win_color = BG_COLOR;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        win_hit   = 1'b1;
        win_id    = IDX_W'(i);
        win_color = s1_color[i];
      end
    end
  end

  logic               multi_hit;
  logic [NUM_OBJ-1:0] acc_q;
  logic [NUM_OBJ-1:0] acc_d;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hit = (s1_hit & (s1_hit - NUM_OBJ'(1))) != '0;
  assign acc_d     = acc_q | ((s1_valid && multi_hit) ? s1_hit : '0);

  // Stage 2 outputs and per-frame collision accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_id    <= '0;
      out_color <= BG_COLOR;
      acc_q     <= '0;
      collide   <= '0;
    end else begin
      out_valid <= s1_valid;
      out_hit   <= win_hit;
      out_id    <= win_id;
      out_color <= win_color;
      if (frame_start) begin
        collide <= acc_d;
        acc_q   <= '0;
      end else begin
        acc_q   <= acc_d;
      end
    end
  end

endmodule

// File: tb/tb_display_rect_compositor.sv
// Self-checking bench: directed scenarios followed by random traffic, both
// compared every cycle against a pixel-level reference model. A second DUT
// with three objects exercises out-of-range write indices.
module tb_display_rect_compositor;

  localparam int COORD_W = 10;
  localparam int SIZE_W  = 8;
  localparam int COLOR_W = 3;
  localparam int BG      = 0;

  logic               clk = 1'b0;
  logic               reset;
  logic               frame_start;
  logic               wr_en;
  logic [1:0]         wr_idx;
  logic [COORD_W-1:0] wr_x, wr_y;
  logic [SIZE_W-1:0]  wr_w, wr_h;
  logic [COLOR_W-1:0] wr_color;
  logic               wr_vis;
  logic               pix_valid;
  logic [COORD_W-1:0] xpix, ypix;

  logic               a_valid, a_hit, b_valid, b_hit;
  logic [1:0]         a_id, b_id;
  logic [COLOR_W-1:0] a_color, b_color;
  logic [3:0]         a_collide;
  logic [2:0]         b_collide;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  display_rect_compositor #(.NUM_OBJ(4)) dut_a (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
    .wr_w(wr_w), .wr_h(wr_h), .wr_color(wr_color), .wr_vis(wr_vis),
    .pix_valid(pix_valid), .xpix(xpix), .ypix(ypix),
    .out_valid(a_valid), .out_hit(a_hit), .out_id(a_id),
    .out_color(a_color), .collide(a_collide)
  );

  display_rect_compositor #(.NUM_OBJ(3)) dut_b (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
    .wr_w(wr_w), .wr_h(wr_h), .wr_color(wr_color), .wr_vis(wr_vis),
    .pix_valid(pix_valid), .xpix(xpix), .ypix(ypix),
    .out_valid(b_valid), .out_hit(b_hit), .out_id(b_id),
    .out_color(b_color), .collide(b_collide)
  );

  // ---------------- reference model (index 0: 4 objects, 1: 3 objects)
  typedef struct {
    int x, y, w, h, color;
    bit vis;
  } mobj_t;

  typedef struct {
    bit valid, hit;
    int id, color, vec;
  } rec_t;

  mobj_t m_shadow [2][4];
  mobj_t m_active [2][4];
  rec_t  m_inflight [2];
  rec_t  e_out [2];
  int    m_acc [2];
  int    m_collide [2];

  function automatic int nobj(input int m);
    return (m == 0) ? 4 : 3;
  endfunction

  function automatic rec_t idle_rec();
    rec_t r;
    r.valid = 0; r.hit = 0; r.id = 0; r.color = BG; r.vec = 0;
    return r;
  endfunction

  function automatic int popcount(input int v);
    int c = 0;
    for (int i = 0; i < 32; i++) c += (v >> i) & 1;
    return c;
  endfunction

  // What the pixel currently on the inputs should produce two cycles later.
  function automatic rec_t evaluate(input int m);
    rec_t r;
    int   px, py;
    r  = idle_rec();
    px = int'(xpix);
    py = int'(ypix);
    r.valid = pix_valid;
    if (pix_valid) begin
      for (int i = 0; i < nobj(m); i++) begin
        mobj_t o;
        o = m_active[m][i];
        if (o.vis && px >= o.x && px < o.x + o.w && py >= o.y && py < o.y + o.h) begin
          r.vec |= (1 << i);
          if (!r.hit) begin
            r.hit = 1; r.id = i; r.color = o.color;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: advance model and DUT together, then compare all outputs.
  task automatic step();
    rec_t cur [2];
    for (int m = 0; m < 2; m++) cur[m] = evaluate(m);
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        for (int i = 0; i < 4; i++) begin
          m_shadow[m][i] = '{x: 0, y: 0, w: 0, h: 0, color: 0, vis: 0};
          m_active[m][i] = '{x: 0, y: 0, w: 0, h: 0, color: 0, vis: 0};
        end
        m_inflight[m] = idle_rec();
        e_out[m]      = idle_rec();
        m_acc[m]      = 0;
        m_collide[m]  = 0;
      end else begin
        e_out[m]      = m_inflight[m];
        m_inflight[m] = cur[m];
        if (e_out[m].valid && popcount(e_out[m].vec) >= 2) m_acc[m] |= e_out[m].vec;
        if (wr_en && int'(wr_idx) < nobj(m)) begin
          m_shadow[m][wr_idx] = '{x: int'(wr_x), y: int'(wr_y), w: int'(wr_w),
                                  h: int'(wr_h), color: int'(wr_color), vis: wr_vis};
        end
        if (frame_start) begin
          for (int i = 0; i < 4; i++) m_active[m][i] = m_shadow[m][i];
          m_collide[m] = m_acc[m];
          m_acc[m]     = 0;
        end
      end
    end
    #1;
    check("a_valid",   32'(a_valid),   32'(e_out[0].valid));
    check("a_hit",     32'(a_hit),     32'(e_out[0].hit));
    check("a_id",      32'(a_id),      32'(e_out[0].id));
    check("a_color",   32'(a_color),   32'(e_out[0].color));
    check("a_collide", 32'(a_collide), 32'(m_collide[0]));
    check("b_valid",   32'(b_valid),   32'(e_out[1].valid));
    check("b_hit",     32'(b_hit),     32'(e_out[1].hit));
    check("b_id",      32'(b_id),      32'(e_out[1].id));
    check("b_color",   32'(b_color),   32'(e_out[1].color));
    check("b_collide", 32'(b_collide), 32'(m_collide[1]));
  endtask

  task automatic wr(input int idx, input int x, input int y, input int w,
                    input int h, input int c, input bit vis);
    wr_en = 1'b1; wr_idx = 2'(idx);
    wr_x = 10'(x); wr_y = 10'(y); wr_w = 8'(w); wr_h = 8'(h);
    wr_color = 3'(c); wr_vis = vis;
    step();
    wr_en = 1'b0;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic px(input int x, input int y);
    pix_valid = 1'b1; xpix = 10'(x); ypix = 10'(y);
    step();
    pix_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; wr_en = 1'b0; wr_idx = '0;
    wr_x = '0; wr_y = '0; wr_w = '0; wr_h = '0; wr_color = '0; wr_vis = 1'b0;
    pix_valid = 1'b0; xpix = '0; ypix = '0;

    // Reset state.
    step(); step();
    reset = 1'b0;
    check("rst_valid", 32'(a_valid), 0);
    check("rst_color", 32'(a_color), BG);
    check("rst_collide", 32'(a_collide), 0);

    // Basic hit test on obj0 (100,200) 8x64 colour 3.
    wr(0, 100, 200, 8, 64, 3, 1);
    fs();
    px(100, 200);
    px(108, 200);
    check("p100_200_hit", 32'(a_hit), 1);
    check("p100_200_id", 32'(a_id), 0);
    check("p100_200_color", 32'(a_color), 3);
    px(107, 263);
    check("p108_200_hit", 32'(a_hit), 0);
    check("p108_200_color", 32'(a_color), BG);
    step();
    check("p107_263_hit", 32'(a_hit), 1);

    // Shadow write without commit; commit with a same-cycle pixel.
    wr(0, 300, 300, 8, 8, 2, 1);
    px(300, 300);
    step();
    check("uncommitted_hit", 32'(a_hit), 0);
    frame_start = 1'b1; pix_valid = 1'b1; xpix = 10'd300; ypix = 10'd300;
    step();
    frame_start = 1'b0;
    px(300, 300);
    check("fs_pixel_hit", 32'(a_hit), 0);
    step();
    check("post_fs_hit", 32'(a_hit), 1);
    check("post_fs_color", 32'(a_color), 2);

    // Overlap of obj1 and obj2.
    wr(0, 0, 0, 0, 0, 0, 0);
    wr(1, 40, 40, 20, 20, 5, 1);
    wr(2, 45, 45, 10, 10, 6, 1);
    fs();
    px(50, 50);
    step();
    check("overlap_id", 32'(a_id), 1);
    check("overlap_color", 32'(a_color), 5);
    fs();
    check("collide_a", 32'(a_collide), 32'h6);
    check("collide_b", 32'(b_collide), 32'h6);
    wr(2, 500, 500, 4, 4, 6, 1);
    fs();
    check("collide_clear", 32'(a_collide), 0);

    // Right-edge object must not wrap to x=0..3.
    wr(3, 1020, 10, 8, 4, 7, 1);
    fs();
    px(2, 10);
    px(1023, 10);
    check("nowrap_hit", 32'(a_hit), 0);
    step();
    check("edge_hit", 32'(a_hit), 1);
    check("edge_id", 32'(a_id), 3);

    // Zero-width object, and index 3 is out of range for the 3-object DUT.
    wr(0, 200, 10, 0, 4, 1, 1);
    wr(3, 600, 600, 8, 8, 4, 1);
    fs();
    px(200, 10);
    px(600, 600);
    check("zero_w_hit", 32'(a_hit), 0);
    px(50, 50);
    check("idx3_a_hit", 32'(a_hit), 1);
    check("idx3_b_hit", 32'(b_hit), 0);
    step();
    check("b_obj1_hit", 32'(b_hit), 1);
    check("b_obj1_id", 32'(b_id), 1);
    check("b_obj1_color", 32'(b_color), 5);

    // Mid-stream reset with a continuous pixel stream.
    pix_valid = 1'b1; xpix = 10'd50; ypix = 10'd50;
    step(); step(); step();
    check("pre_rst_valid", 32'(a_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", 32'(a_valid), 0);
    check("mid_rst_hit", 32'(a_hit), 0);
    check("mid_rst_color", 32'(a_color), BG);
    check("mid_rst_collide", 32'(a_collide), 0);
    step();
    check("post_rst_valid1", 32'(a_valid), 0);
    step();
    check("post_rst_valid2", 32'(a_valid), 1);
    pix_valid = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bit near;
      reset       = ($urandom_range(0, 999) == 0);
      frame_start = ($urandom_range(0, 39) == 0);
      wr_en       = ($urandom_range(0, 3) == 0);
      wr_idx      = 2'($urandom_range(0, 3));
      near        = ($urandom_range(0, 7) == 0);
      wr_x        = near ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 60));
      wr_y        = 10'($urandom_range(0, 60));
      wr_w        = 8'($urandom_range(0, 24));
      wr_h        = 8'($urandom_range(0, 24));
      wr_color    = 3'($urandom_range(0, 7));
      wr_vis      = ($urandom_range(0, 4) != 0);
      pix_valid   = ($urandom_range(0, 4) != 0);
      near        = ($urandom_range(0, 7) == 0);
      xpix        = near ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 70));
      ypix        = 10'($urandom_range(0, 70));
      step();
    end
    reset = 1'b0; frame_start = 1'b0; wr_en = 1'b0; pix_valid = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
